// File: rtl/beep_pattern_monitor.sv
// beep_pattern_monitor: measures buzzer on/off intervals and validates a beep pattern.
// Define BEEP_MON_DUR_OUT_EN to expose last_on_ticks / last_off_ticks.
module beep_pattern_monitor #(
  parameter int unsigned TICK_CYCLES  = 1_000_000,
  parameter int unsigned ON_MIN       = 40,
  parameter int unsigned ON_MAX       = 110,
  parameter int unsigned OFF_MIN      = 40,
  parameter int unsigned OFF_MAX      = 110,
  parameter int unsigned IDLE_TIMEOUT = 200,
  parameter int unsigned EXP_BEEPS    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arm,
  input  logic       buzzer_in,
  output logic       busy,
  output logic       done,
  output logic       pattern_ok,
  output logic [3:0] beep_count,
  output logic [1:0] err_code
`ifdef BEEP_MON_DUR_OUT_EN
  ,
  output logic [15:0] last_on_ticks,
  output logic [15:0] last_off_ticks
`endif
);

  localparam int unsigned PW =
    (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_TERM = PW'(TICK_CYCLES - 1);
  localparam logic [PW-1:0] PRE_ONE =
    (TICK_CYCLES > 1) ? PW'(1) : PW'(0);

  localparam logic [15:0] ON_MIN_T  = 16'(ON_MIN);
  localparam logic [15:0] ON_MAX_T  = 16'(ON_MAX);
  localparam logic [15:0] OFF_MIN_T = 16'(OFF_MIN);
  localparam logic [15:0] OFF_MAX_T = 16'(OFF_MAX);
  localparam logic [15:0] TO_T      = 16'(IDLE_TIMEOUT);
  localparam logic [3:0]  EXP_T     = 4'(EXP_BEEPS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ON,
    S_MEAS_ON,
    S_MEAS_OFF,
    S_REPORT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic          s1, s2, s3;
  logic          rise_q, fall_q;
  logic          any_edge;
  logic          arm_acc;
  logic          tick;
  logic [PW-1:0] pre_q;
  logic [15:0]   dur_q;
  logic          on_ok, off_ok, on_long, to_hit;
  logic [1:0]    err_d;
  logic          beep_inc;
  logic          enter_rep;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1     <= buzzer_in;
      s2     <= s1;
      s3     <= s2;
      rise_q <= s2 & ~s3;
      fall_q <= ~s2 & s3;
    end
  end

  assign any_edge = rise_q | fall_q;
  assign arm_acc  = (state_q == S_IDLE) & arm;
  assign tick     = (pre_q == PRE_TERM) & ~any_edge;

  // The restart cycle itself is count 0, so the next cycle holds 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      dur_q <= '0;
    end else if (any_edge || arm_acc) begin
      pre_q <= PRE_ONE;
      dur_q <= '0;
    end else begin
      pre_q <= tick ? '0 : pre_q + PW'(1);
      if (tick && dur_q != 16'hFFFF)
        dur_q <= dur_q + 16'd1;
    end
  end

  assign on_ok   = (dur_q >= ON_MIN_T) && (dur_q <= ON_MAX_T);
  assign off_ok  = (dur_q >= OFF_MIN_T) && (dur_q <= OFF_MAX_T);
  assign on_long = dur_q > ON_MAX_T;
  assign to_hit  = dur_q >= TO_T;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    err_d    = err_code;
    beep_inc = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (arm) state_d = S_WAIT_ON;
      end
      S_WAIT_ON: begin
        if (rise_q) begin
          state_d = S_MEAS_ON;
        end else if (to_hit) begin
          err_d   = 2'd3;
          state_d = S_REPORT;
        end
      end
      S_MEAS_ON: begin
        if (fall_q) begin
          if (!on_ok) begin
            err_d   = 2'd1;
            state_d = S_REPORT;
          end else if (beep_count == EXP_T) begin
            err_d   = 2'd3;
            state_d = S_REPORT;
          end else begin
            beep_inc = 1'b1;
            state_d  = S_MEAS_OFF;
          end
        end else if (on_long) begin
          err_d   = 2'd1;
          state_d = S_REPORT;
        end
      end
      S_MEAS_OFF: begin
        if (rise_q) begin
          if (off_ok) begin
            state_d = S_MEAS_ON;
          end else begin
            err_d   = 2'd2;
            state_d = S_REPORT;
          end
        end else if (to_hit) begin
          err_d   = (beep_count == EXP_T) ? 2'd0 : 2'd3;
          state_d = S_REPORT;
        end
      end
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign enter_rep = (state_d == S_REPORT) && (state_q != S_REPORT);

  always_ff @(posedge clk) begin
    if (rst) begin
      beep_count <= '0;
      err_code   <= '0;
      pattern_ok <= 1'b0;
    end else if (arm_acc) begin
      beep_count <= '0;
      err_code   <= '0;
      pattern_ok <= 1'b0;
    end else begin
      if (beep_inc && beep_count != 4'hF)
        beep_count <= beep_count + 4'd1;
      if (enter_rep) begin
        err_code   <= err_d;
        pattern_ok <= (err_d == 2'd0);
      end
    end
  end

`ifdef BEEP_MON_DUR_OUT_EN
  always_ff @(posedge clk) begin
    if (rst || arm_acc) begin
      last_on_ticks  <= '0;
      last_off_ticks <= '0;
    end else begin
      if (state_q == S_MEAS_ON && fall_q)
        last_on_ticks <= dur_q;
      if (state_q == S_MEAS_OFF) begin
        if (rise_q)      last_off_ticks <= dur_q;
        else if (to_hit) last_off_ticks <= TO_T;
      end
    end
  end
`endif

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      S_WAIT_ON,
      S_MEAS_ON,
      S_MEAS_OFF: busy = 1'b1;
      S_REPORT:   done = 1'b1;
      default:    busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_beep_pattern_monitor.sv
// tb_beep_pattern_monitor: random beep patterns vs an interval-level model.
// Model works on edge times and floor(len/TICK) durations only.
module tb_beep_pattern_monitor;

  localparam int TC   = 10;
  localparam int ONMN = 4;
  localparam int ONMX = 6;
  localparam int OFMN = 4;
  localparam int OFMX = 6;
  localparam int TO   = 20;
  localparam int EXP  = 3;
  localparam int LAT  = 3;
  localparam int TAIL = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       arm;
  logic       buzzer_in;
  logic       busy;
  logic       done;
  logic       pattern_ok;
  logic [3:0] beep_count;
  logic [1:0] err_code;
`ifdef BEEP_MON_DUR_OUT_EN
  logic [15:0] last_on_ticks;
  logic [15:0] last_off_ticks;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  int lead;
  int on_q[$];
  int off_q[$];

  always #5 clk = ~clk;

  beep_pattern_monitor #(
    .TICK_CYCLES (TC),
    .ON_MIN      (ONMN),
    .ON_MAX      (ONMX),
    .OFF_MIN     (OFMN),
    .OFF_MAX     (OFMX),
    .IDLE_TIMEOUT(TO),
    .EXP_BEEPS   (EXP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .arm       (arm),
    .buzzer_in (buzzer_in),
    .busy      (busy),
    .done      (done),
    .pattern_ok(pattern_ok),
    .beep_count(beep_count),
    .err_code  (err_code)
`ifdef BEEP_MON_DUR_OUT_EN
    ,
    .last_on_ticks (last_on_ticks),
    .last_off_ticks(last_off_ticks)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  // Buzzer level at drive index i of the current pattern.
  function automatic logic level_at(input int i);
    int t;
    if (i < lead) return 1'b0;
    t = i - lead;
    foreach (on_q[k]) begin
      if (k >= off_q.size()) return 1'b1;
      if (t < on_q[k]) return 1'b1;
      t -= on_q[k];
      if (t < off_q[k]) return 1'b0;
      t -= off_q[k];
    end
    return 1'b0;
  endfunction

  // Expected done cycle (arm cycle = 0), error code, beep count.
  task automatic model(output int d, output int e, output int c);
    int r, f, len, g;
    bit fin;
    c = 0;
    e = 3;
    d = TO * TC + 1;
    fin = 0;
    if (on_q.size() == 0) return;
    r = lead + LAT;
    for (int k = 0; k < on_q.size() && !fin; k++) begin
      len = (k < off_q.size()) ? on_q[k] : 100000;
      if (len >= (ONMX + 1) * TC) begin
        e = 1;
        d = r + (ONMX + 1) * TC + 1;
        fin = 1;
      end else begin
        f = r + len;
        if (len / TC < ONMN) begin
          e = 1; d = f + 1; fin = 1;
        end else if (c == EXP) begin
          e = 3; d = f + 1; fin = 1;
        end else begin
          c++;
          g = off_q[k];
          if (g >= TO * TC) begin
            e = (c == EXP) ? 0 : 3;
            d = f + TO * TC + 1;
            fin = 1;
          end else if (g / TC < OFMN || g / TC > OFMX) begin
            e = 2; d = f + g + 1; fin = 1;
          end else begin
            r = f + g;
          end
        end
      end
    end
  endtask

  task automatic run_trial(input string nm, input bit poke_en);
    int d, e, c, poke, seen, at;
    logic [1:0] err_at;
    logic [3:0] cnt_at;
    logic ok_at, busy_b, busy_a;
    model(d, e, c);
    buzzer_in = 1'b0;
    arm = 1'b0;
    repeat (6) @(posedge clk);
    poke = (poke_en && d > 10) ? $urandom_range(2, d - 2) : -1;
    seen = 0;
    at = -1;
    err_at = '0; cnt_at = '0; ok_at = 1'b0;
    busy_b = 1'b0; busy_a = 1'b1;
    for (int i = 0; i <= d + 12; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen++;
        if (at < 0) begin
          at = i;
          err_at = err_code;
          cnt_at = beep_count;
          ok_at = pattern_ok;
        end
      end
      if (i == d - 1) busy_b = busy;
      if (i == d) busy_a = busy;
      arm = (i == 0) || (i == poke);
      buzzer_in = level_at(i);
    end
    arm = 1'b0;
    buzzer_in = 1'b0;
    chk({nm, ".done_n"}, seen, 1);
    chk({nm, ".done_at"}, at, d);
    chk({nm, ".err"}, err_at, e);
    chk({nm, ".cnt"}, cnt_at, c);
    chk({nm, ".ok"}, ok_at, e == 0);
    chk({nm, ".busy_pre"}, busy_b, 1);
    chk({nm, ".busy_post"}, busy_a, 0);
    chk({nm, ".hold_err"}, err_code, e);
    chk({nm, ".hold_cnt"}, beep_count, c);
  endtask

  function automatic int pick_len();
    int r;
    r = $urandom_range(0, 7);
    if (r < 5) return $urandom_range(40, 69);
    if (r == 5) return $urandom_range(25, 39);
    return $urandom_range(70, 90);
  endfunction

  task automatic set_pat(input int ld, input int n_on,
                         input int on_len, input int off_len);
    lead = ld;
    on_q.delete();
    off_q.delete();
    for (int k = 0; k < n_on; k++) begin
      on_q.push_back(on_len);
      off_q.push_back(k == n_on - 1 ? TAIL : off_len);
    end
  endtask

  initial begin
    int nb, dn;
    rst = 1'b1;
    arm = 1'b0;
    buzzer_in = 1'b0;
    lead = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.ok", pattern_ok, 0);
    chk("rst.cnt", beep_count, 0);
    chk("rst.err", err_code, 0);
    rst = 1'b0;

    set_pat(10, 3, 50, 50);
    run_trial("s1_three", 1'b0);
    set_pat(10, 2, 50, 50);
    run_trial("s2_two", 1'b0);
    set_pat(10, 1, 50, 0);
    off_q.delete();
    run_trial("s3_stuck", 1'b0);
    set_pat(10, 2, 50, 20);
    run_trial("s4_gap", 1'b0);
    set_pat(10, 4, 50, 50);
    run_trial("s4_four", 1'b0);
    set_pat(10, 0, 0, 0);
    run_trial("s5_none", 1'b1);

    // Reset during the second on-pulse of a capture.
    buzzer_in = 1'b0;
    repeat (6) @(posedge clk);
    dn = 0;
    for (int i = 0; i <= 400; i++) begin
      @(posedge clk);
      #1;
      if (done) dn++;
      if (i == 140) begin
        chk("mid.cnt", beep_count, 1);
        chk("mid.busy", busy, 1);
      end
      if (i == 141) begin
        chk("rstm.busy", busy, 0);
        chk("rstm.done", done, 0);
        chk("rstm.cnt", beep_count, 0);
        chk("rstm.err", err_code, 0);
        chk("rstm.ok", pattern_ok, 0);
      end
      arm = (i == 0);
      rst = (i == 140);
      buzzer_in = (i >= 5 && i < 55) || (i >= 105 && i < 300);
    end
    chk("rstm.no_done", dn, 0);
    set_pat(10, 3, 50, 50);
    run_trial("s6_after_rst", 1'b0);

    for (int t = 0; t < 24; t++) begin
      lead = $urandom_range(1, 100);
      nb = $urandom_range(0, 5);
      on_q.delete();
      off_q.delete();
      for (int k = 0; k < nb; k++) begin
        on_q.push_back(pick_len());
        off_q.push_back(k == nb - 1 ? TAIL : pick_len());
      end
      if (nb > 0 && $urandom_range(0, 7) == 0)
        off_q.delete(off_q.size() - 1);
      run_trial($sformatf("rnd%0d", t), $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
